// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file (2 comb read ports, 1 write port) with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_sb #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rs_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rs_data,
  output logic             rd_busy,
  output logic             rs_busy,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic [DEPTH-1:0] busy_vec
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] l_hit;

  // Register 0 is never written or locked when hardwired to zero, so it stays at its reset value.
  function automatic logic writable(input int unsigned idx);
    return !(ZERO_REG != 0 && idx == 0);
  endfunction

  // One-hot write/lock decode; addresses >= DEPTH match nothing and are dropped.
  always_comb begin
    w_hit = '0;
    l_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_hit[i] = w_en && (w_addr == AW'(i)) && writable(i);
      l_hit[i] = lock_en && (lock_addr == AW'(i)) && writable(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_hit[i]) regs[i] <= w_data;
        // A new lock on the same edge as the write wins: the register is pending again.
        if (l_hit[i])      busy[i] <= 1'b1;
        else if (w_hit[i]) busy[i] <= 1'b0;
      end
    end
  end

  // Read mux; forwarding is suppressed during reset so outputs read zero.
  always_comb begin
    rd_data = '0;
    rs_data = '0;
    rd_busy = 1'b0;
    rs_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = regs[i];
        rd_busy = busy[i];
        if (BYPASS && w_hit[i] && !reset) begin
          rd_data = w_data;
          rd_busy = l_hit[i];
        end
      end
      if (rs_addr == AW'(i)) begin
        rs_data = regs[i];
        rs_busy = busy[i];
        if (BYPASS && w_hit[i] && !reset) begin
          rs_data = w_data;
          rs_busy = l_hit[i];
        end
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default 4x8 instance plus a 6x16 zero-register instance against an array model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [1:0]  a_rd_addr, a_rs_addr, a_w_addr, a_lock_addr;
  logic [7:0]  a_rd_data, a_rs_data, a_w_data;
  logic        a_rd_busy, a_rs_busy, a_w_en, a_lock_en;
  logic [3:0]  a_busy_vec;

  logic [2:0]  b_rd_addr, b_rs_addr, b_w_addr, b_lock_addr;
  logic [15:0] b_rd_data, b_rs_data, b_w_data;
  logic        b_rd_busy, b_rs_busy, b_w_en, b_lock_en;
  logic [5:0]  b_busy_vec;

  regfile_sb dut_a (
    .clock(clock), .reset(reset),
    .rd_addr(a_rd_addr), .rs_addr(a_rs_addr), .rd_data(a_rd_data), .rs_data(a_rs_data),
    .rd_busy(a_rd_busy), .rs_busy(a_rs_busy), .w_en(a_w_en), .w_addr(a_w_addr),
    .w_data(a_w_data), .lock_en(a_lock_en), .lock_addr(a_lock_addr), .busy_vec(a_busy_vec)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut_b (
    .clock(clock), .reset(reset),
    .rd_addr(b_rd_addr), .rs_addr(b_rs_addr), .rd_data(b_rd_data), .rs_data(b_rs_data),
    .rd_busy(b_rd_busy), .rs_busy(b_rs_busy), .w_en(b_w_en), .w_addr(b_w_addr),
    .w_data(b_w_data), .lock_en(b_lock_en), .lock_addr(b_lock_addr), .busy_vec(b_busy_vec)
  );

  // Reference state: narrow instance (ma/mba) and wide instance (mb/mbb).
  logic [7:0]  ma [4];
  logic [3:0]  mba;
  logic [15:0] mb [6];
  logic [5:0]  mbb;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ma[i] = '0;
    for (int i = 0; i < 6; i++) mb[i] = '0;
    mba = '0;
    mbb = '0;
  endtask

  function automatic bit addr_ok(input bit wide, input int addr);
    if (!wide) return addr < 4;
    return addr < 6 && addr != 0;
  endfunction

  function automatic logic [15:0] exp_data(input bit wide, input int addr, input bit we,
                                           input int wa, input logic [15:0] wd);
    if (!addr_ok(wide, addr)) return 16'h0;
    if (BYPASS && we && wa == addr) return wd;
    return wide ? mb[addr] : 16'(ma[addr]);
  endfunction

  function automatic bit exp_busy(input bit wide, input int addr, input bit we, input int wa,
                                  input bit le, input int la);
    if (!addr_ok(wide, addr)) return 1'b0;
    if (BYPASS && we && wa == addr) return le && la == addr;
    return wide ? mbb[addr] : mba[addr];
  endfunction

  task automatic model_edge(input bit wide, input bit we, input int wa, input logic [15:0] wd,
                            input bit le, input int la);
    if (we && addr_ok(wide, wa)) begin
      if (wide) begin mb[wa] = wd; mbb[wa] = 1'b0; end
      else begin ma[wa] = wd[7:0]; mba[wa] = 1'b0; end
    end
    if (le && addr_ok(wide, la)) begin
      if (wide) mbb[la] = 1'b1;
      else mba[la] = 1'b1;
    end
  endtask

  task automatic drive_a(input bit we, input int wa, input int wd, input bit le, input int la,
                         input int ra, input int sa);
    a_w_en = we; a_w_addr = 2'(wa); a_w_data = 8'(wd);
    a_lock_en = le; a_lock_addr = 2'(la); a_rd_addr = 2'(ra); a_rs_addr = 2'(sa);
  endtask

  task automatic drive_b(input bit we, input int wa, input int wd, input bit le, input int la,
                         input int ra, input int sa);
    b_w_en = we; b_w_addr = 3'(wa); b_w_data = 16'(wd);
    b_lock_en = le; b_lock_addr = 3'(la); b_rd_addr = 3'(ra); b_rs_addr = 3'(sa);
  endtask

  // Advance one rising edge and apply the same inputs to the model.
  task automatic edge_all();
    @(posedge clock);
    model_edge(1'b0, a_w_en, int'(a_w_addr), 16'(a_w_data), a_lock_en, int'(a_lock_addr));
    model_edge(1'b1, b_w_en, int'(b_w_addr), b_w_data, b_lock_en, int'(b_lock_addr));
  endtask

  task automatic test_reset();
    drive_a(0, 0, 0, 0, 0, 2, 3);
    drive_b(0, 0, 0, 0, 0, 5, 7);
    model_reset();
    #2;
    checks++;
    if (a_busy_vec !== 4'h0 || a_rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_init: busy_vec=%h rd_data=%h, want 0 0", a_busy_vec, a_rd_data);
    end
    @(negedge clock) reset = 1'b0;
    @(negedge clock) drive_a(1, 2, 'hA5, 1, 3, 2, 3);
    edge_all();
    @(negedge clock) drive_a(1, 2, 'h5A, 1, 1, 2, 3);
    #1;
    checks++;
    if (a_busy_vec !== 4'b1000) begin
      errors++; $display("FAIL pre_reset_busy: busy_vec=%b, want 1000", a_busy_vec);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (a_rd_data !== 8'h00 || a_rs_busy !== 1'b0 || a_busy_vec !== 4'h0) begin
      errors++; $display("FAIL async_reset: rd_data=%h rs_busy=%b busy_vec=%b, want 00 0 0000",
                         a_rd_data, a_rs_busy, a_busy_vec);
    end
    drive_a(0, 0, 0, 0, 0, 2, 3);
    @(negedge clock) reset = 1'b0;
    #1;
    checks++;
    if (a_rd_data !== 8'h00 || b_busy_vec !== 6'h0) begin
      errors++; $display("FAIL post_reset: rd_data=%h b_busy_vec=%b, want 00 0", a_rd_data, b_busy_vec);
    end
  endtask

  task automatic test_basic_write();
    @(negedge clock) drive_a(1, 1, 'h3C, 0, 0, 0, 0);
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (a_rd_data !== 8'h3C || a_rs_data !== 8'h3C) begin
      errors++; $display("FAIL basic_write: rd=%h rs=%h, want 3c 3c", a_rd_data, a_rs_data);
    end
    a_rs_addr = 2'd0;
    #1;
    checks++;
    if (a_rs_data !== 8'h00) begin
      errors++; $display("FAIL basic_r0: rs=%h, want 00", a_rs_data);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clock) drive_a(0, 0, 0, 1, 2, 2, 0);
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 2, 0);
    #1;
    checks++;
    if (a_rd_busy !== 1'b1 || a_busy_vec !== 4'b0100) begin
      errors++; $display("FAIL sb_lock: rd_busy=%b busy_vec=%b, want 1 0100", a_rd_busy, a_busy_vec);
    end
    edge_all();
    @(negedge clock) drive_a(1, 2, 'h77, 0, 0, 2, 0);
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 2, 0);
    #1;
    checks++;
    if (a_busy_vec !== 4'b0000 || a_rd_data !== 8'h77 || a_rd_busy !== 1'b0) begin
      errors++; $display("FAIL sb_write: busy_vec=%b rd_data=%h rd_busy=%b, want 0000 77 0",
                         a_busy_vec, a_rd_data, a_rd_busy);
    end
  endtask

  task automatic test_lock_write_same();
    @(negedge clock) drive_a(0, 0, 0, 1, 1, 1, 1);
    edge_all();
    @(negedge clock) drive_a(1, 1, 'h11, 1, 1, 1, 1);
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (a_rd_data !== 8'h11 || a_busy_vec[1] !== 1'b1) begin
      errors++; $display("FAIL lock_write_same: rd=%h busy1=%b, want 11 1", a_rd_data, a_busy_vec[1]);
    end
    @(negedge clock) drive_a(1, 0, 'h22, 1, 3, 0, 3);
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 0, 3);
    #1;
    checks++;
    if (a_rd_data !== 8'h22 || a_rs_busy !== 1'b1 || a_busy_vec !== 4'b1010) begin
      errors++; $display("FAIL lock_write_diff: rd=%h rs_busy=%b busy_vec=%b, want 22 1 1010",
                         a_rd_data, a_rs_busy, a_busy_vec);
    end
  endtask

  task automatic test_bypass();
    @(negedge clock) drive_a(1, 3, 'h5A, 1, 3, 0, 3);
    edge_all();
    @(negedge clock) drive_a(1, 3, 'hF0, 0, 0, 0, 3);
    #1;
    checks++;
    if (a_rs_data !== (BYPASS ? 8'hF0 : 8'h5A) || a_rs_busy !== !BYPASS) begin
      errors++; $display("FAIL bypass_pre_edge: rs=%h rs_busy=%b, want %h %b",
                         a_rs_data, a_rs_busy, BYPASS ? 8'hF0 : 8'h5A, !BYPASS);
    end
    a_lock_en = 1'b1; a_lock_addr = 2'd3;
    #1;
    checks++;
    if (a_rs_busy !== 1'b1) begin
      errors++; $display("FAIL bypass_lock_busy: rs_busy=%b, want 1", a_rs_busy);
    end
    a_lock_en = 1'b0;
    edge_all();
    @(negedge clock) drive_a(0, 0, 0, 0, 0, 3, 3);
    #1;
    checks++;
    if (a_rs_data !== 8'hF0 || a_rs_busy !== 1'b0) begin
      errors++; $display("FAIL bypass_post_edge: rs=%h rs_busy=%b, want f0 0", a_rs_data, a_rs_busy);
    end
  endtask

  task automatic test_wide();
    @(negedge clock) drive_b(1, 0, 'h1234, 1, 0, 0, 0);
    edge_all();
    @(negedge clock) drive_b(1, 7, 'hAAAA, 1, 7, 0, 7);
    #1;
    checks++;
    if (b_rd_data !== 16'h0000 || b_rd_busy !== 1'b0 || b_busy_vec !== 6'h00) begin
      errors++; $display("FAIL zero_reg: rd=%h rd_busy=%b busy_vec=%b, want 0000 0 000000",
                         b_rd_data, b_rd_busy, b_busy_vec);
    end
    checks++;
    if (b_rs_data !== 16'h0000 || b_rs_busy !== 1'b0) begin
      errors++; $display("FAIL oor_read_comb: rs=%h rs_busy=%b, want 0000 0", b_rs_data, b_rs_busy);
    end
    edge_all();
    @(negedge clock) drive_b(1, 5, 'hBEEF, 0, 0, 5, 7);
    edge_all();
    @(negedge clock) drive_b(0, 0, 0, 0, 0, 5, 7);
    #1;
    checks++;
    if (b_rd_data !== 16'hBEEF || b_rs_data !== 16'h0000 || b_rs_busy !== 1'b0 || b_busy_vec !== 6'h00) begin
      errors++; $display("FAIL wide_r5_oor: rd=%h rs=%h rs_busy=%b busy_vec=%b, want beef 0000 0 000000",
                         b_rd_data, b_rs_data, b_rs_busy, b_busy_vec);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      drive_a(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      drive_b(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
              $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      #1;
      e = exp_data(1'b0, int'(a_rd_addr), a_w_en, int'(a_w_addr), 16'(a_w_data));
      checks++;
      if (a_rd_data !== 8'(e)) begin
        errors++; $display("FAIL rand_a_rd n=%0d: got %h want %h", n, a_rd_data, 8'(e));
      end
      e = exp_data(1'b0, int'(a_rs_addr), a_w_en, int'(a_w_addr), 16'(a_w_data));
      checks++;
      if (a_rs_data !== 8'(e)) begin
        errors++; $display("FAIL rand_a_rs n=%0d: got %h want %h", n, a_rs_data, 8'(e));
      end
      checks++;
      if (a_rd_busy !== exp_busy(1'b0, int'(a_rd_addr), a_w_en, int'(a_w_addr), a_lock_en, int'(a_lock_addr)) ||
          a_rs_busy !== exp_busy(1'b0, int'(a_rs_addr), a_w_en, int'(a_w_addr), a_lock_en, int'(a_lock_addr)) ||
          a_busy_vec !== mba) begin
        errors++; $display("FAIL rand_a_busy n=%0d: rd_busy=%b rs_busy=%b busy_vec=%b model_vec=%b",
                           n, a_rd_busy, a_rs_busy, a_busy_vec, mba);
      end
      e = exp_data(1'b1, int'(b_rd_addr), b_w_en, int'(b_w_addr), b_w_data);
      checks++;
      if (b_rd_data !== e) begin
        errors++; $display("FAIL rand_b_rd n=%0d: got %h want %h", n, b_rd_data, e);
      end
      e = exp_data(1'b1, int'(b_rs_addr), b_w_en, int'(b_w_addr), b_w_data);
      checks++;
      if (b_rs_data !== e) begin
        errors++; $display("FAIL rand_b_rs n=%0d: got %h want %h", n, b_rs_data, e);
      end
      checks++;
      if (b_rd_busy !== exp_busy(1'b1, int'(b_rd_addr), b_w_en, int'(b_w_addr), b_lock_en, int'(b_lock_addr)) ||
          b_rs_busy !== exp_busy(1'b1, int'(b_rs_addr), b_w_en, int'(b_w_addr), b_lock_en, int'(b_lock_addr)) ||
          b_busy_vec !== mbb) begin
        errors++; $display("FAIL rand_b_busy n=%0d: rd_busy=%b rs_busy=%b busy_vec=%b model_vec=%b",
                           n, b_rd_busy, b_rs_busy, b_busy_vec, mbb);
      end
      edge_all();
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_scoreboard();
    test_lock_write_same();
    test_bypass();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
